// File: rtl/reg_dump_ctrl_pkg.sv
// Shared definitions for the register-dump sequencer: instruction fields, state encoding, tag payload.
package reg_dump_ctrl_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NUM_REGS  = 32;

    // ADDI opcode; field layout is opcode[31:26] rs[25:21] rt[20:16] imm[15:0]
    localparam logic [5:0]      OP_ADDI  = 6'b001000;
    localparam logic [XLEN-1:0] NOP_WORD = {OP_ADDI, 26'b0};

    typedef enum logic [2:0] {
        DUMP_IDLE  = 3'd0,
        DUMP_DRAIN = 3'd1,
        DUMP_DUMP  = 3'd2,
        DUMP_FLUSH = 3'd3,
        DUMP_DONE  = 3'd4
    } dump_state_e;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] idx;
    } dump_tag_t;

    // ADDI r0, rk, 0: puts rk on read port A without changing architectural state
    function automatic logic [XLEN-1:0] read_word(input logic [REG_IDX_W-1:0] k);
        return {OP_ADDI, k, 5'b0, 16'b0};
    endfunction

endpackage

// File: rtl/reg_dump_ctrl_tag_delay.sv
// LATENCY-stage shift register carrying {valid, index} alongside the pipeline read latency.
module dump_tag_delay
    import reg_dump_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic      clk,
    input  logic      reset,
    input  dump_tag_t tag_i,
    output dump_tag_t tag_o
);

    dump_tag_t stage_q [LATENCY];

    // Shift tags one stage per cycle; reset flushes everything in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < int'(LATENCY); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[LATENCY-1];

endmodule

// File: rtl/reg_dump_ctrl.sv
// Register-dump sequencer: forces drain/read instructions into the pipeline and streams (index, value) beats.
module reg_dump_ctrl
    import reg_dump_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned LATENCY      = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [XLEN-1:0]      instruction,
    input  logic [XLEN-1:0]      busA_probe,
    output logic [XLEN-1:0]      inst_out,
    output logic                 override,
    output logic                 busy,
    output logic                 dump_valid,
    output logic [REG_IDX_W-1:0] dump_reg,
    output logic [XLEN-1:0]      dump_data,
    output logic                 done
);

    // One down-counter serves both the drain and the flush waits
    localparam int unsigned MAX_WAIT = (DRAIN_CYCLES > LATENCY) ? DRAIN_CYCLES : LATENCY;
    localparam int unsigned WAIT_W   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [REG_IDX_W-1:0] LAST_REG = REG_IDX_W'(NUM_REGS - 1);

    dump_state_e          state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [REG_IDX_W-1:0] issue_q, issue_d;

    logic                 override_q, override_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dump_valid_q, dump_valid_d;
    logic [REG_IDX_W-1:0] dump_reg_q, dump_reg_d;
    logic [XLEN-1:0]      dump_data_q, dump_data_d;

    dump_tag_t            tag_in_c, tag_out_c;
    logic [XLEN-1:0]      forced_word_c;

    // Tag each read issue so the captured probe value carries its register index
    assign tag_in_c.valid = (state_q == DUMP_DUMP);
    assign tag_in_c.idx   = issue_q;

    dump_tag_delay #(
        .LATENCY (LATENCY)
    ) u_tag_delay (
        .clk   (clk),
        .reset (reset),
        .tag_i (tag_in_c),
        .tag_o (tag_out_c)
    );

    // Forced word: read instruction while issuing, NOP during drain and flush
    assign forced_word_c = (state_q == DUMP_DUMP) ? read_word(issue_q) : NOP_WORD;
    assign inst_out      = override_q ? forced_word_c : instruction;

    // State, counters and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= DUMP_IDLE;
            wait_q       <= '0;
            issue_q      <= '0;
            override_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_reg_q   <= '0;
            dump_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            issue_q      <= issue_d;
            override_q   <= override_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            dump_valid_q <= dump_valid_d;
            dump_reg_q   <= dump_reg_d;
            dump_data_q  <= dump_data_d;
        end
    end

    // Next-state sequencing and next values of the registered outputs
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        issue_d      = issue_q;
        override_d   = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        dump_valid_d = 1'b0;
        dump_reg_d   = dump_reg_q;
        dump_data_d  = dump_data_q;

        unique case (state_q)
            DUMP_IDLE: begin
                if (start) begin
                    state_d = DUMP_DRAIN;
                    wait_d  = WAIT_W'(DRAIN_CYCLES - 1);
                end
            end
            DUMP_DRAIN: begin
                if (wait_q == '0) begin
                    state_d = DUMP_DUMP;
                    issue_d = '0;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            DUMP_DUMP: begin
                // Exit on the explicit last index rather than relying on counter wrap
                if (issue_q == LAST_REG) begin
                    state_d = DUMP_FLUSH;
                    wait_d  = WAIT_W'(LATENCY - 1);
                end else begin
                    issue_d = issue_q + REG_IDX_W'(1);
                end
            end
            DUMP_FLUSH: begin
                if (wait_q == '0) begin
                    state_d = DUMP_DONE;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            DUMP_DONE: begin
                state_d = DUMP_IDLE;
            end
            default: begin
                state_d = DUMP_IDLE;
            end
        endcase

        override_d = (state_d == DUMP_DRAIN) || (state_d == DUMP_DUMP) || (state_d == DUMP_FLUSH);
        busy_d     = (state_d != DUMP_IDLE);
        done_d     = (state_d == DUMP_DONE);

        dump_valid_d = tag_out_c.valid;
        if (tag_out_c.valid) begin
            dump_reg_d  = tag_out_c.idx;
            dump_data_d = busA_probe;
        end
    end

    assign override   = override_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dump_valid = dump_valid_q;
    assign dump_reg   = dump_reg_q;
    assign dump_data  = dump_data_q;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Bench for reg_dump_ctrl: two parameterisations run side by side against a pipeline/regfile model.
module tb_reg_dump_ctrl;

    localparam int DA = 4;
    localparam int LA = 1;
    localparam int DB = 2;
    localparam int LB = 3;
    localparam logic [31:0] NOP = 32'h2000_0000;

    typedef struct packed {
        logic        busy;
        logic        ovr;
        logic        valid;
        logic        done;
        logic [31:0] inst;
        logic [4:0]  r;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] instruction = 32'h0;

    logic [31:0] bus_a, bus_b;
    logic [31:0] inst_a, inst_b;
    logic        ovr_a, ovr_b, busy_a, busy_b, valid_a, valid_b, done_a, done_b;
    logic [4:0]  reg_a, reg_b;
    logic [31:0] data_a, data_b;

    logic [31:0] regs [32];
    logic [31:0] hist_a [LA];
    logic [31:0] hist_b [LB];

    int checks = 0;
    int errors = 0;
    int beats_a, beats_b, dones_a, dones_b;

    always #5 clk = ~clk;

    reg_dump_ctrl u_dut_a (
        .clk (clk), .reset (reset), .start (start), .instruction (instruction),
        .busA_probe (bus_a), .inst_out (inst_a), .override (ovr_a), .busy (busy_a),
        .dump_valid (valid_a), .dump_reg (reg_a), .dump_data (data_a), .done (done_a)
    );

    reg_dump_ctrl #(.DRAIN_CYCLES (DB), .LATENCY (LB)) u_dut_b (
        .clk (clk), .reset (reset), .start (start), .instruction (instruction),
        .busA_probe (bus_b), .inst_out (inst_b), .override (ovr_b), .busy (busy_b),
        .dump_valid (valid_b), .dump_reg (reg_b), .dump_data (data_b), .done (done_b)
    );

    // Pipeline model: port A shows the rs register of the word presented L cycles earlier
    initial begin
        for (int i = 0; i < LA; i++) hist_a[i] = 32'h0;
        for (int i = 0; i < LB; i++) hist_b[i] = 32'h0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    end

    always @(posedge clk) begin
        hist_a[0] <= inst_a;
        hist_b[0] <= inst_b;
        for (int i = 1; i < LB; i++) hist_b[i] <= hist_b[i-1];
    end

    assign bus_a = regs[hist_a[LA-1][25:21]];
    assign bus_b = regs[hist_b[LB-1][25:21]];

    // Expected outputs t cycles after the start-high cycle (t<=0 or past the end means idle)
    function automatic exp_t expect_at(int t, int d, int l, logic [31:0] instr);
        exp_t e;
        int   total;
        total  = d + l + 33;
        e      = '0;
        e.inst = instr;
        if (t >= 1 && t <= total) begin
            e.busy = 1'b1;
            e.ovr  = (t <= total - 1);
            e.done = (t == total);
            if (t <= d)               e.inst = NOP;
            else if (t <= d + 32)     e.inst = NOP + (32'(t - d - 1) << 21);
            else if (t <= d + 32 + l) e.inst = NOP;
            if (t >= d + l + 2) begin
                e.valid = 1'b1;
                e.r     = 5'(t - (d + l + 2));
                e.data  = regs[t - (d + l + 2)];
            end
        end
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @%0t: observed %h expected %h", name, $time, obs, exp);
        end
    endtask

    task automatic check_both(int t);
        exp_t ea, eb;
        ea = expect_at(t, DA, LA, instruction);
        eb = expect_at(t, DB, LB, instruction);
        chk("A.busy",     32'(busy_a),  32'(ea.busy));
        chk("A.override", 32'(ovr_a),   32'(ea.ovr));
        chk("A.valid",    32'(valid_a), 32'(ea.valid));
        chk("A.done",     32'(done_a),  32'(ea.done));
        chk("A.inst_out", inst_a,       ea.inst);
        if (ea.valid) begin
            chk("A.dump_reg",  32'(reg_a), 32'(ea.r));
            chk("A.dump_data", data_a,     ea.data);
        end
        chk("B.busy",     32'(busy_b),  32'(eb.busy));
        chk("B.override", 32'(ovr_b),   32'(eb.ovr));
        chk("B.valid",    32'(valid_b), 32'(eb.valid));
        chk("B.done",     32'(done_b),  32'(eb.done));
        chk("B.inst_out", inst_b,       eb.inst);
        if (eb.valid) begin
            chk("B.dump_reg",  32'(reg_b), 32'(eb.r));
            chk("B.dump_data", data_b,     eb.data);
        end
        if (valid_a) beats_a++;
        if (valid_b) beats_b++;
        if (done_a)  dones_a++;
        if (done_b)  dones_b++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        beats_a = 0; beats_b = 0; dones_a = 0; dones_b = 0;
    endtask

    // One dump: start in t=0, optional extra pulses, optional hold and restart offset
    task automatic run_dump(int t_end, int p1, int p2, int hold_until, int restart);
        int tt;
        for (int t = 0; t <= t_end; t++) begin
            instruction = $urandom;
            start = (t == 0) || (t == p1) || (t == p2) || (t <= hold_until);
            tt = (restart > 0 && t >= restart) ? t - restart : t;
            @(negedge clk);
            check_both(tt);
            next_cycle();
        end
        start = 1'b0;
    endtask

    task automatic check_counts(string name, int beats, int dones);
        chk({name, ".beats_a"}, 32'(beats_a), 32'(beats));
        chk({name, ".beats_b"}, 32'(beats_b), 32'(beats));
        chk({name, ".dones_a"}, 32'(dones_a), 32'(dones));
        chk({name, ".dones_b"}, 32'(dones_b), 32'(dones));
    endtask

    initial begin
        // Reset state while held in reset
        instruction = $urandom;
        #1;
        check_both(0);
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // Idle sweep: passthrough, no override, no beats
        clear_counts();
        for (int i = 0; i < 12; i++) begin
            instruction = $urandom;
            @(negedge clk);
            check_both(0);
            next_cycle();
        end

        // Directed preload r_k = A500_0000 + k
        for (int k = 0; k < 32; k++) regs[k] = 32'hA500_0000 + 32'(k);
        clear_counts();
        run_dump(40, -1, -1, -1, 0);
        check_counts("basic", 32, 1);

        // Random register values, start pulsed during DUMP is ignored
        for (int k = 0; k < 32; k++) regs[k] = $urandom;
        clear_counts();
        run_dump(40, 20, 30, -1, 0);
        check_counts("pulse", 32, 1);

        // Start held: second dump accepted from IDLE after DONE
        for (int k = 0; k < 32; k++) regs[k] = $urandom;
        clear_counts();
        run_dump(80, -1, -1, 40, 39);
        check_counts("held", 64, 2);

        // Reset asserted mid-dump: async clear, no done, then a full new dump
        for (int k = 0; k < 32; k++) regs[k] = $urandom;
        clear_counts();
        for (int t = 0; t < 20; t++) begin
            instruction = $urandom;
            start = (t == 0);
            @(negedge clk);
            check_both(t);
            next_cycle();
        end
        instruction = $urandom;
        #2;
        reset = 1'b1;
        #1;
        check_both(0);
        for (int i = 0; i < 3; i++) begin
            instruction = $urandom;
            @(negedge clk);
            check_both(0);
            next_cycle();
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            instruction = $urandom;
            @(negedge clk);
            check_both(0);
            next_cycle();
        end
        check_counts("abort", 20 - (DA + LA + 2), 0);

        for (int k = 0; k < 32; k++) regs[k] = $urandom;
        clear_counts();
        run_dump(40, -1, -1, -1, 0);
        check_counts("after_reset", 32, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
